// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and FSM state encoding for the result requant/packer.
//   DATA_ADDR_WIDTH : BRAM address/data port width
//   BIT_A_RESULT    : signed width of one accumulated core result
//   BIT_OUT_F       : signed width of one output feature
//   FEAT_PER_WORD   : output features packed into one BRAM3 word
package cnn_pkg;

  localparam int DATA_ADDR_WIDTH = 32;
  localparam int BIT_A_RESULT    = 21;
  localparam int BIT_OUT_F       = 8;
  localparam int FEAT_PER_WORD   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational requantiser for one core result.
//   x     in  A_W  signed accumulated result
//   shift in  5    arithmetic right-shift amount
//   y     out F_W  shifted result saturated to the output feature range
// Build option RESULT_REQUANT_RELU_EN: when defined the lower clamp is 0
// (ReLU + saturate); otherwise the full signed range of F_W bits is used.
module requant_sat
  import cnn_pkg::*;
#(
  parameter int A_W = cnn_pkg::BIT_A_RESULT,
  parameter int F_W = cnn_pkg::BIT_OUT_F
) (
  input  logic [A_W-1:0] x,
  input  logic [4:0]     shift,
  output logic [F_W-1:0] y
);

  localparam int HI = (1 << (F_W - 1)) - 1;
`ifdef RESULT_REQUANT_RELU_EN
  localparam int LO = 0;
`else
  localparam int LO = -(1 << (F_W - 1));
`endif

  logic signed [A_W-1:0] shifted;
  logic signed [31:0]    wide;

  always_comb begin
    shifted = $signed(x) >>> shift;
    // Sign-extend once so both clamp bounds compare as plain signed ints.
    wide    = 32'(shifted);
    if (wide > HI) begin
      y = F_W'(HI);
    end else if (wide < LO) begin
      y = F_W'(LO);
    end else begin
      y = wide[F_W-1:0];
    end
  end

endmodule

// File: rtl/result_requant_packer.sv
// result_requant_packer: reads CO core results from BRAM2, requantises each
// to a signed BIT_OUT_F feature and packs four features per word into BRAM3
// (first feature in the most significant byte).
// Build option: RESULT_REQUANT_RELU_EN (ReLU clamp inside requant_sat).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_run, i_shift            start pulse (IDLE only) and shift captured with it
//   o_idle, o_run, o_done     state flags, o_done is a one-cycle pulse
//   o_bram2_*, i_bram2_qout   BRAM2 read port (read-only use)
//   o_bram3_*, i_bram3_qout   BRAM3 write port (qout unused)
// BRAM timing: an enabled read in cycle t presents its data on i_bram2_qout
// in cycle t+1, where it is consumed unconditionally (no back-pressure).
// A BRAM3 write is a single cycle with en = we = 1; en/we are 0 otherwise.
module result_requant_packer
  import cnn_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = cnn_pkg::DATA_ADDR_WIDTH,
  parameter int CO              = 16,
  parameter int BIT_A_RESULT    = cnn_pkg::BIT_A_RESULT,
  parameter int BIT_OUT_F       = cnn_pkg::BIT_OUT_F
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_run,
  input  logic [4:0]                 i_shift,
  output logic                       o_idle,
  output logic                       o_run,
  output logic                       o_done,
  output logic [DATA_ADDR_WIDTH-1:0] o_bram2_addr,
  output logic                       o_bram2_en,
  output logic                       o_bram2_we,
  output logic [DATA_ADDR_WIDTH-1:0] o_bram2_din,
  input  logic [DATA_ADDR_WIDTH-1:0] i_bram2_qout,
  output logic [DATA_ADDR_WIDTH-1:0] o_bram3_addr,
  output logic                       o_bram3_en,
  output logic                       o_bram3_we,
  output logic [DATA_ADDR_WIDTH-1:0] o_bram3_din,
  input  logic [DATA_ADDR_WIDTH-1:0] i_bram3_qout
);

  localparam int               CNT_W    = (CO > 1) ? $clog2(CO) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CO - 1);
  localparam int               WORD_W   = FEAT_PER_WORD * BIT_OUT_F;

  state_t                     state, state_next;
  logic [CNT_W-1:0]           rd_cnt;    // next BRAM2 address to read
  logic [CNT_W-1:0]           in_cnt;    // index of the result currently valid
  logic [1:0]                 byte_cnt;  // slot of that result within its word
  logic [WORD_W-1:0]          word_buf;
  logic [WORD_W-1:0]          word_merged;
  logic [WORD_W-1:0]          wr_word;
  logic [DATA_ADDR_WIDTH-1:0] wr_cnt;
  logic [DATA_ADDR_WIDTH-1:0] wr_addr;
  logic [4:0]                 shift_q;
  logic                       valid_q;
  logic                       wr_en;
  logic                       last_wr;   // the pending write carries the final result
  logic                       group_end;
  logic [BIT_OUT_F-1:0]       feat;
  logic                       unused_bits;

  assign unused_bits = ^{i_bram3_qout, i_bram2_qout[DATA_ADDR_WIDTH-1:BIT_A_RESULT]};

  requant_sat #(
    .A_W (BIT_A_RESULT),
    .F_W (BIT_OUT_F)
  ) u_requant_sat (
    .x     (i_bram2_qout[BIT_A_RESULT-1:0]),
    .shift (shift_q),
    .y     (feat)
  );

  // Drop the current feature into its slot; a word closes on its fourth
  // feature or on the final result (partial word, low slots left zero).
  always_comb begin
    word_merged = word_buf;
    word_merged[BIT_OUT_F*(FEAT_PER_WORD - 1 - int'(byte_cnt)) +: BIT_OUT_F] = feat;
    group_end   = (byte_cnt == 2'(FEAT_PER_WORD - 1)) || (in_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_run) state_next = ST_READ;
      ST_READ:  if (rd_cnt == LAST_IDX) state_next = ST_DRAIN;
      ST_DRAIN: if (wr_en && last_wr) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt   <= '0;
      in_cnt   <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      wr_word  <= '0;
      wr_cnt   <= '0;
      wr_addr  <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      wr_en    <= 1'b0;
      last_wr  <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      last_wr <= 1'b0;
      valid_q <= (state == ST_READ);
      if (state == ST_IDLE && i_run) begin
        shift_q  <= i_shift;
        rd_cnt   <= '0;
        in_cnt   <= '0;
        byte_cnt <= '0;
        word_buf <= '0;
        wr_cnt   <= '0;
      end
      if (state == ST_READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (valid_q) begin
        in_cnt <= in_cnt + 1'b1;
        if (group_end) begin
          wr_en    <= 1'b1;
          last_wr  <= (in_cnt == LAST_IDX);
          wr_word  <= word_merged;
          wr_addr  <= wr_cnt;
          wr_cnt   <= wr_cnt + 1'b1;
          word_buf <= '0;
          byte_cnt <= '0;
        end else begin
          word_buf <= word_merged;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  assign o_idle       = (state == ST_IDLE);
  assign o_run        = (state == ST_READ) || (state == ST_DRAIN);
  assign o_done       = (state == ST_DONE);
  assign o_bram2_en   = (state == ST_READ);
  assign o_bram2_addr = DATA_ADDR_WIDTH'(rd_cnt);
  assign o_bram2_we   = 1'b0;
  assign o_bram2_din  = '0;
  assign o_bram3_en   = wr_en;
  assign o_bram3_we   = wr_en;
  assign o_bram3_addr = wr_addr;
  assign o_bram3_din  = DATA_ADDR_WIDTH'(wr_word);

endmodule

// File: tb/tb_result_requant_packer.sv
// Bench for result_requant_packer: two instances (CO=16 and CO=6) with
// behavioural BRAM models; every run is compared against a reference built
// from the requantise/saturate/pack rules with plain integer arithmetic.
module tb_result_requant_packer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: CO = 16 ----------------
  logic        a_run, a_idle, a_busy, a_done;
  logic [4:0]  a_shift;
  logic [31:0] a_b2_addr, a_b2_din, a_b2_q, a_b3_addr, a_b3_din;
  logic        a_b2_en, a_b2_we, a_b3_en, a_b3_we;
  logic [31:0] mem_a[16];

  result_requant_packer #(.CO(16)) dut_a (
    .clk(clk), .reset_n(rst_n), .i_run(a_run), .i_shift(a_shift),
    .o_idle(a_idle), .o_run(a_busy), .o_done(a_done),
    .o_bram2_addr(a_b2_addr), .o_bram2_en(a_b2_en), .o_bram2_we(a_b2_we),
    .o_bram2_din(a_b2_din), .i_bram2_qout(a_b2_q),
    .o_bram3_addr(a_b3_addr), .o_bram3_en(a_b3_en), .o_bram3_we(a_b3_we),
    .o_bram3_din(a_b3_din), .i_bram3_qout(32'hDEAD_BEEF)
  );

  // ---------------- instance B: CO = 6 ----------------
  logic        b_run, b_idle, b_busy, b_done;
  logic [4:0]  b_shift;
  logic [31:0] b_b2_addr, b_b2_din, b_b2_q, b_b3_addr, b_b3_din;
  logic        b_b2_en, b_b2_we, b_b3_en, b_b3_we;
  logic [31:0] mem_b[8];

  result_requant_packer #(.CO(6)) dut_b (
    .clk(clk), .reset_n(rst_n), .i_run(b_run), .i_shift(b_shift),
    .o_idle(b_idle), .o_run(b_busy), .o_done(b_done),
    .o_bram2_addr(b_b2_addr), .o_bram2_en(b_b2_en), .o_bram2_we(b_b2_we),
    .o_bram2_din(b_b2_din), .i_bram2_qout(b_b2_q),
    .o_bram3_addr(b_b3_addr), .o_bram3_en(b_b3_en), .o_bram3_we(b_b3_we),
    .o_bram3_din(b_b3_din), .i_bram3_qout(32'h0)
  );

  // BRAM2 models: one-cycle read latency
  always @(posedge clk) if (a_b2_en) a_b2_q <= mem_a[a_b2_addr[3:0]];
  always @(posedge clk) if (b_b2_en) b_b2_q <= mem_b[b_b2_addr[2:0]];

  // ---------------- monitors (sampled on the falling edge) ----------------
  int          a_start = 0, b_start = 0;
  int          a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0, b_done_cyc = 0;
  int          a_rd_bad = 0, b_rd_bad = 0;
  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int          wa_cyc[$], wb_cyc[$];
  logic        wa_we[$], wb_we[$];

  always @(negedge clk) begin
    if (a_b3_en) begin
      wa_addr.push_back(a_b3_addr); wa_data.push_back(a_b3_din);
      wa_cyc.push_back(cyc - a_start); wa_we.push_back(a_b3_we);
    end
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc - a_start; end
    if (a_b2_en && a_b2_addr != 32'(cyc - a_start - 1)) a_rd_bad++;
    if (a_b2_we || a_b2_din != 32'h0) a_rd_bad++;
  end

  always @(negedge clk) begin
    if (b_b3_en) begin
      wb_addr.push_back(b_b3_addr); wb_data.push_back(b_b3_din);
      wb_cyc.push_back(cyc - b_start); wb_we.push_back(b_b3_we);
    end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc - b_start; end
    if (b_b2_en && b_b2_addr != 32'(cyc - b_start - 1)) b_rd_bad++;
    if (b_b2_we || b_b2_din != 32'h0) b_rd_bad++;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] first_word;

  function automatic logic [7:0] sat_ref(input logic [31:0] v, input logic [4:0] s);
    logic [20:0] low;
    int x, y, lo;
    low = v[20:0];
    x   = int'($signed(low));
    y   = x >>> s;
`ifdef RESULT_REQUANT_RELU_EN
    lo  = 0;
`else
    lo  = -128;
`endif
    if (y > 127) y = 127;
    if (y < lo) y = lo;
    return 8'(y);
  endfunction

  task automatic build_exp(input int which, input logic [4:0] sh);
    int n;
    logic [31:0] w, v;
    n = (which == 0) ? 16 : 6;
    exp_q.delete();
    w = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = (which == 0) ? mem_a[i] : mem_b[i];
      w = w | ({24'h0, sat_ref(v, sh)} << (24 - 8 * (i % 4)));
      if ((i % 4) == 3 || i == n - 1) begin
        exp_q.push_back(w);
        w = 32'h0;
      end
    end
  endtask

  // ---------------- driver: one complete run ----------------
  task automatic run_check(input int which, input logic [4:0] sh, input bit disturb,
                           input logic [4:0] sh2, input string tag);
    int n, base, d0, cnt, last_idx;
    logic [31:0] got_d, got_a;
    int got_c;
    logic got_w;
    n = (which == 0) ? 16 : 6;
    build_exp(which, sh);
    @(negedge clk); #1;
    if (which == 0) begin
      base = wa_addr.size(); d0 = a_done_cnt; a_shift = sh; a_run = 1'b1; a_start = cyc;
    end else begin
      base = wb_addr.size(); d0 = b_done_cnt; b_shift = sh; b_run = 1'b1; b_start = cyc;
    end
    @(negedge clk); #1;
    a_run = 1'b0; b_run = 1'b0;
    if (disturb) begin
      // restart attempt and shift change while reading
      repeat (2) @(negedge clk);
      #1;
      if (which == 0) begin a_run = 1'b1; a_shift = sh2; end
      else begin b_run = 1'b1; b_shift = sh2; end
      @(negedge clk); #1;
      a_run = 1'b0; b_run = 1'b0;
    end
    for (int t = 0; t < 200; t++) begin
      if (((which == 0) ? a_done_cnt : b_done_cnt) != d0) break;
      @(negedge clk); #1;
    end
    check({tag, " done seen"}, 32'(((which == 0) ? a_done_cnt : b_done_cnt) != d0), 32'd1);
    check({tag, " done cycle"}, 32'((which == 0) ? a_done_cyc : b_done_cyc), 32'(n + 3));
    @(negedge clk); #1;
    check({tag, " idle after done"}, 32'((which == 0) ? a_idle : b_idle), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    cnt = ((which == 0) ? wa_addr.size() : wb_addr.size()) - base;
    check({tag, " write count"}, 32'(cnt), 32'(exp_q.size()));
    for (int k = 0; k < cnt && k < exp_q.size(); k++) begin
      if (which == 0) begin
        got_d = wa_data[base + k]; got_a = wa_addr[base + k]; got_c = wa_cyc[base + k]; got_w = wa_we[base + k];
      end else begin
        got_d = wb_data[base + k]; got_a = wb_addr[base + k]; got_c = wb_cyc[base + k]; got_w = wb_we[base + k];
      end
      if (k == 0) first_word = got_d;
      last_idx = (4 * k + 3 < n - 1) ? 4 * k + 3 : n - 1;
      check($sformatf("%s w%0d data", tag, k), got_d, exp_q[k]);
      check($sformatf("%s w%0d addr", tag, k), got_a, 32'(k));
      check($sformatf("%s w%0d cycle", tag, k), 32'(got_c), 32'(last_idx + 3));
      check($sformatf("%s w%0d we", tag, k), 32'(got_w), 32'd1);
    end
  endtask

  function automatic logic [31:0] rand_result();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 3000));
      default: return 32'(2097152 - int'($urandom_range(1, 3000)));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  int base_r;

  initial begin
    rst_n = 1'b0;
    a_run = 1'b0; b_run = 1'b0; a_shift = '0; b_shift = '0;
    for (int i = 0; i < 16; i++) mem_a[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem_b[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst a idle", 32'(a_idle), 32'd1);
    check("rst a run", 32'(a_busy), 32'd0);
    check("rst a done", 32'(a_done), 32'd0);
    check("rst a b2_en", 32'(a_b2_en), 32'd0);
    check("rst a b2_addr", a_b2_addr, 32'd0);
    check("rst a b3_en", 32'(a_b3_en), 32'd0);
    check("rst a b3_addr", a_b3_addr, 32'd0);
    check("rst a b3_din", a_b3_din, 32'd0);
    check("rst b idle", 32'(b_idle), 32'd1);
    check("rst b b3_en", 32'(b_b3_en), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst a idle", 32'(a_idle), 32'd1);

    // ascending 1..16, no shift
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i + 1);
    run_check(0, 5'd0, 1'b0, 5'd0, "seq16");
    check("seq16 literal w0", first_word, 32'h0102_0304);

    // saturation, exact shift, negative value, junk above the result field
    for (int i = 0; i < 16; i++) mem_a[i] = rand_result();
    mem_a[0] = 32'h000F_FFFF; mem_a[1] = 32'h0000_0100;
    mem_a[2] = 32'h001F_FF00; mem_a[3] = 32'hFFE0_0010;
    run_check(0, 5'd4, 1'b0, 5'd0, "sat4");
`ifdef RESULT_REQUANT_RELU_EN
    check("sat4 literal w0", first_word, 32'h7F10_0001);
`else
    check("sat4 literal w0", first_word, 32'h7F10_F001);
`endif
    mem_a[0] = 32'h001F_FF00;
    run_check(0, 5'd0, 1'b0, 5'd0, "neg256");
`ifdef RESULT_REQUANT_RELU_EN
    check("neg256 literal b0", {24'h0, first_word[31:24]}, 32'h00);
`else
    check("neg256 literal b0", {24'h0, first_word[31:24]}, 32'h80);
`endif

    // partial final word
    for (int i = 0; i < 6; i++) mem_b[i] = 32'(i + 1);
    run_check(1, 5'd0, 1'b0, 5'd0, "co6");
    check("co6 literal w0", first_word, 32'h0102_0304);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem_a[i] = rand_result();
      run_check(0, 5'($urandom_range(0, 12)), 1'b0, 5'd0, $sformatf("rnd_a%0d", r));
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) mem_b[i] = rand_result();
      run_check(1, 5'($urandom_range(0, 12)), 1'b0, 5'd0, $sformatf("rnd_b%0d", r));
    end

    // i_run and i_shift disturbed mid-run
    for (int i = 0; i < 16; i++) mem_a[i] = rand_result();
    run_check(0, 5'd3, 1'b1, 5'd17, "disturb");

    // reset in the middle of a run
    for (int i = 0; i < 16; i++) mem_a[i] = 32'(i + 1);
    @(negedge clk); #1;
    base_r = wa_addr.size();
    a_shift = 5'd0; a_run = 1'b1; a_start = cyc;
    @(negedge clk); #1;
    a_run = 1'b0;
    for (int t = 0; t < 20 && (cyc - a_start) < 8; t++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort idle", 32'(a_idle), 32'd1);
    check("abort run", 32'(a_busy), 32'd0);
    check("abort b2_en", 32'(a_b2_en), 32'd0);
    check("abort b3_en", 32'(a_b3_en), 32'd0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort write count", 32'(wa_addr.size() - base_r), 32'd1);
    if (wa_addr.size() > base_r) begin
      check("abort w0 data", wa_data[base_r], 32'h0102_0304);
      check("abort w0 cycle", 32'(wa_cyc[base_r]), 32'd6);
    end
    run_check(0, 5'd0, 1'b0, 5'd0, "after_abort");

    check("a read port protocol", 32'(a_rd_bad), 32'd0);
    check("b read port protocol", 32'(b_rd_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_requant_packer.md
RESULT_REQUANT_PACKER -- requirements
Module: result_requant_packer

Interface
REQ-001 SHALL have parameter DATA_ADDR_WIDTH, default 32: BRAM address and data port width.
REQ-002 SHALL have parameter CO, default 16: number of core results (one per BRAM2 word).
REQ-003 SHALL have parameter BIT_A_RESULT, default 21: signed result width held in each BRAM2 word.
REQ-004 SHALL have parameter BIT_OUT_F, default 8: signed output feature width; 4 features per 32-bit word.
REQ-005 SHALL have one clock and an asynchronous active-low reset; ports listed below.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 i_run  in  1  start pulse, sampled only in IDLE.
REQ-009 i_shift  in  5  arithmetic right-shift amount, captured on accepted i_run.
REQ-010 o_idle / o_run / o_done  out  1 each  state flags; o_done is a one-cycle pulse.
REQ-011 o_bram2_addr  out  DATA_ADDR_WIDTH  BRAM2 read address; o_bram2_en, o_bram2_we  out  1; o_bram2_din  out  DATA_ADDR_WIDTH; i_bram2_qout  in  DATA_ADDR_WIDTH.
REQ-012 o_bram3_addr  out  DATA_ADDR_WIDTH  packed-word write address; o_bram3_en, o_bram3_we  out  1; o_bram3_din  out  DATA_ADDR_WIDTH; i_bram3_qout  in  DATA_ADDR_WIDTH (unused).

Function
REQ-013 SHALL implement FSM IDLE -> READ (accepted i_run) -> DRAIN (last read address issued) -> DONE (final packed word written) -> IDLE (unconditional).
REQ-014 o_run SHALL be high in READ and DRAIN; o_idle only in IDLE; o_done only in DONE.
REQ-015 In READ, o_bram2_en SHALL be 1 and o_bram2_addr SHALL step 0..CO-1, one per cycle, zero-extended; o_bram2_we and o_bram2_din SHALL be constant 0.
REQ-016 Read data SHALL be taken as valid exactly one cycle after each enabled read (1-cycle BRAM latency).
REQ-017 Each valid word: x = signed i_bram2_qout[BIT_A_RESULT-1:0]; y = x >>> shift; y saturated to the output range (REQ-026).
REQ-018 Results SHALL be packed first-in into bits [31:24], then [23:16], [15:8], [7:0].
REQ-019 The cycle after the 4th byte of a word is valid, o_bram3_en = o_bram3_we = 1 for exactly one cycle with the packed word; word address starts at 0 and increments per write.
REQ-020 If CO mod 4 != 0, the final partial word SHALL be written the cycle after its last byte, unused low bytes 0.
REQ-021 With CO=16, i_run accepted at cycle 0: reads cycles 1..16, writes cycles 6,10,14,18 at addresses 0..3, o_done at cycle 19, IDLE at cycle 20.
REQ-022 i_run outside IDLE SHALL be ignored; i_shift changes after capture SHALL have no effect.
REQ-023 o_bram3_en/we SHALL be 0 except on write cycles.

Reset
REQ-024 On reset_n low, FSM SHALL go to IDLE immediately; counters, byte buffer, captured shift, valid pipe SHALL clear; all outputs 0 except o_idle=1.
REQ-025 Reset asserted mid-operation SHALL abort with no further BRAM3 write; the partial word is discarded.

Configuration
REQ-026 Macro RESULT_REQUANT_RELU_EN: defined -> clamp y to [0,127] (ReLU + saturate); undefined -> clamp y to [-128,127].

Structure
REQ-027 Shared package cnn_pkg SHALL hold FSM state encodings, DATA_ADDR_WIDTH, BIT_A_RESULT, BIT_OUT_F, and features-per-word constant 4.
REQ-028 Shift/saturate/ReLU SHALL be a combinational sub-module requant_sat; packing, counters, and FSM stay in the top.

Verification
REQ-029 CO=16, shift=0, BRAM2 = 1..16 -> BRAM3 words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; o_done at cycle 19.
REQ-030 shift=4, inputs 0x0FFFFF (positive, 21 bits) and 0x000100 -> bytes 0x7F (saturated) and 0x10.
REQ-031 Input 0x1FFF00 (-256), shift=0 -> 0x80 without macro; 0x00 with RESULT_REQUANT_RELU_EN.
REQ-032 CO=6, inputs 1..6 -> words 0x01020304, 0x05060000; exactly 2 writes.
REQ-033 reset_n low at cycle 8 of a run -> only the write at cycle 6 occurs; o_idle=1 immediately; a new i_run completes normally.
REQ-034 i_run pulsed during READ and i_shift changed mid-run -> no restart; output uses the captured shift.
